// File: rtl/router_pkg.sv
// Shared constants and entry layout for the router ingress path.
// Imported by the queue top and its storage sub-module.
package router_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int ADDR_W     = 2;
  localparam int DROP_CNT_W = 8;
  localparam int DATA_W     = 32;

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// full/empty derive only from the registered count.
module sync_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = ADDR_W + DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/router_ingress_queue.sv
// Ingress queue: buffers {addr,data}, drops words for disabled ports,
// and forwards eligible heads through a registered output stage.
module router_ingress_queue
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       out_ready,
  input  logic [NUM_PORTS-1:0]       port_en,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_en,
  output logic [ADDR_W-1:0]          dout_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int EW = ADDR_W + DATA_WIDTH;

  logic [EW-1:0]         head;
  logic [ADDR_W-1:0]     head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  fwd;
  logic                  drop;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0]     dout_addr_q, dout_addr_d;
  logic                  dout_en_q, dout_en_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  assign head_addr = head[EW-1 -: ADDR_W];
  assign head_data = head[DATA_WIDTH-1:0];

  // A disabled head is discarded even when downstream is stalled.
  assign fwd  = ~fifo_empty & port_en[head_addr] & out_ready;
  assign drop = ~fifo_empty & ~port_en[head_addr];

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fwd | drop),
    .wdata ({in_addr, in_data}),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    dout_d      = '0;
    dout_addr_d = '0;
    dout_en_d   = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    if (fwd) begin
      dout_d      = head_data;
      dout_addr_d = head_addr;
      dout_en_d   = 1'b1;
    end
    if (drop && drop_cnt_q != DROP_MAX) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      dout_addr_q <= '0;
      dout_en_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      dout_q      <= dout_d;
      dout_addr_q <= dout_addr_d;
      dout_en_q   <= dout_en_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign dout_addr = dout_addr_q;
  assign dout_en   = dout_en_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_router_ingress_queue.sv
// Directed bench for router_ingress_queue (DEPTH=8, DATA_WIDTH=32).
module tb_router_ingress_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_addr;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic [3:0]  port_en;
  logic [31:0] dout;
  logic        dout_en;
  logic [1:0]  dout_addr;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  router_ingress_queue #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .port_en   (port_en),
    .dout      (dout),
    .dout_en   (dout_en),
    .dout_addr (dout_addr),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    port_en = 4'hF; in_data = '0; in_addr = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    port_en = 4'hF; in_data = '0; in_addr = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (dout_en !== 1'b0) begin
      fails++; $display("FAIL rst_dout_en got %0b exp 0", dout_en);
    end
    tests++;
    if (count !== 4'd0) begin
      fails++; $display("FAIL rst_count got %0d exp 0", count);
    end
    tests++;
    if (drop_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_drop_cnt got %0d exp 0", drop_cnt);
    end
    tests++;
    if (dout !== 32'd0 || dout_addr !== 2'd0) begin
      fails++; $display("FAIL rst_dout got %h/%0d exp 0/0", dout, dout_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_in_ready got %0b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 2'd2; in_data = 32'hA5A5_A5A5;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (dout_en !== 1'b0) begin
      fails++; $display("FAIL basic_no_bypass got %0b exp 0", dout_en);
    end
    tests++;
    if (count !== 4'd1) begin
      fails++; $display("FAIL basic_count got %0d exp 1", count);
    end
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b1 || dout !== 32'hA5A5_A5A5 || dout_addr !== 2'd2) begin
      fails++;
      $display("FAIL basic_fwd got en=%0b d=%h a=%0d exp 1/a5a5a5a5/2",
               dout_en, dout, dout_addr);
    end
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b0 || dout !== 32'd0 || dout_addr !== 2'd0) begin
      fails++;
      $display("FAIL basic_pulse got en=%0b d=%h a=%0d exp 0/0/0",
               dout_en, dout, dout_addr);
    end
  endtask

  task automatic test_full();
    logic [1:0] a;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 32'h100 + i;
      a = i[1:0];
      in_addr = a;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (count !== 4'd8) begin
      fails++; $display("FAIL full_count got %0d exp 8", count);
    end
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL full_in_ready got %0b exp 0", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a = k[1:0];
      tests++;
      if (dout_en !== 1'b1 || dout !== 32'h100 + k || dout_addr !== a) begin
        fails++;
        $display("FAIL full_drain%0d got en=%0b d=%h a=%0d exp 1/%h/%0d",
                 k, dout_en, dout, dout_addr, 32'h100 + k, a);
      end
    end
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b0 || count !== 4'd0) begin
      fails++;
      $display("FAIL full_empty got en=%0b cnt=%0d exp 0/0", dout_en, count);
    end
  endtask

  task automatic test_drop();
    do_reset();
    port_en = 4'b1101;
    in_valid = 1'b1;
    in_addr = 2'd0; in_data = 32'h300; @(negedge clk);
    in_addr = 2'd1; in_data = 32'h301; @(negedge clk);
    in_addr = 2'd3; in_data = 32'h303; @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b1 || dout !== 32'h300 || dout_addr !== 2'd0) begin
      fails++;
      $display("FAIL drop_fwd0 got en=%0b d=%h a=%0d exp 1/300/0",
               dout_en, dout, dout_addr);
    end
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b0 || drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL drop_discard got en=%0b drops=%0d exp 0/1",
               dout_en, drop_cnt);
    end
    @(negedge clk);
    tests++;
    if (dout_en !== 1'b1 || dout !== 32'h303 || dout_addr !== 2'd3) begin
      fails++;
      $display("FAIL drop_fwd3 got en=%0b d=%h a=%0d exp 1/303/3",
               dout_en, dout, dout_addr);
    end
    @(negedge clk);
    tests++;
    if (count !== 4'd0 || drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL drop_end got cnt=%0d drops=%0d exp 0/1", count, drop_cnt);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    in_valid = 1'b1; in_addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h200 + i;
      @(negedge clk);
    end
    tests++;
    if (count !== 4'd4) begin
      fails++; $display("FAIL conc_fill got %0d exp 4", count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'h204 + k;
      @(negedge clk);
      tests++;
      if (count !== 4'd4 || dout_en !== 1'b1 || dout !== 32'h200 + k) begin
        fails++;
        $display("FAIL conc_step%0d got cnt=%0d en=%0b d=%h exp 4/1/%h",
                 k, count, dout_en, dout, 32'h200 + k);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (dout_en !== 1'b1 || dout !== 32'h20A + k) begin
        fails++;
        $display("FAIL conc_drain%0d got en=%0b d=%h exp 1/%h",
                 k, dout_en, dout, 32'h20A + k);
      end
    end
  endtask

  task automatic test_saturation();
    int seen;
    seen = 0;
    do_reset();
    port_en = 4'b1110;
    out_ready = 1'b1;
    in_addr = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = i;
      @(negedge clk);
      if (dout_en === 1'b1) seen++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (dout_en === 1'b1) seen++;
    @(negedge clk);
    tests++;
    if (drop_cnt !== 8'd255) begin
      fails++; $display("FAIL sat_drop_cnt got %0d exp 255", drop_cnt);
    end
    tests++;
    if (count !== 4'd0) begin
      fails++; $display("FAIL sat_count got %0d exp 0", count);
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL sat_no_fwd got %0d pulses exp 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_reset();
    port_en = 4'b1110;
    in_valid = 1'b1; in_addr = 2'd0; in_data = 32'h400;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    port_en = 4'hF;
    in_valid = 1'b1; in_addr = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h410 + i;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (count !== 4'd5 || drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL mid_pre got cnt=%0d drops=%0d exp 5/1", count, drop_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (count !== 4'd0 || dout_en !== 1'b0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_flush got cnt=%0d en=%0b drops=%0d exp 0/0/0",
               count, dout_en, drop_cnt);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_in_ready got %0b exp 1", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dout_en === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0 || drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_stale got %0d pulses drops=%0d exp 0/0",
               seen, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_drop();
    test_concurrent();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/router_ingress_queue.md
ROUTER_INGRESS_QUEUE -- requirements
Module: router_ingress_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of payload word.
REQ-002 Parameter DEPTH, default 8: queue entries, power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  DATA_WIDTH  payload offered by source.
REQ-006 in_addr  input  2  destination port (0..3) for in_data.
REQ-007 in_valid  input  1  source offers in_data/in_addr this cycle.
REQ-008 in_ready  output  1  queue accepts this cycle.
REQ-009 out_ready  input  1  router stage may take a word this cycle.
REQ-010 port_en  input  4  per-destination enable; bit i gates port i.
REQ-011 dout  output  DATA_WIDTH  payload to router din.
REQ-012 dout_en  output  1  qualifies dout; drives router din_en.
REQ-013 dout_addr  output  2  drives router addr.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 drop_cnt  output  8  saturating count of discarded words.

Function
REQ-016 Push SHALL occur on an edge where in_valid && in_ready; entry stores {in_addr, in_data}.
REQ-017 in_ready SHALL equal (count < DEPTH), combinational from registered count only; no push when full, even with a simultaneous pop.
REQ-018 Head "eligible" SHALL mean count != 0 && port_en[head_addr] == 1.
REQ-019 Pop-forward SHALL occur on an edge where head eligible && out_ready; dout/dout_addr load head entry, dout_en loads 1.
REQ-020 Pop-drop SHALL occur on an edge where count != 0 && port_en[head_addr] == 0, regardless of out_ready; entry discarded, dout_en loads 0, drop_cnt increments.
REQ-021 drop_cnt SHALL saturate at 255 and never wrap.
REQ-022 On any edge without pop-forward, dout_en, dout and dout_addr SHALL load 0.
REQ-023 dout, dout_addr, dout_en SHALL be registered outputs; no combinational path from in_* to dout*.
REQ-024 Latency: word pushed into empty queue on edge E SHALL appear with dout_en=1 after edge E+1 at earliest (no bypass).
REQ-025 At most one pop per edge; strict FIFO order among forwarded words.
REQ-026 Simultaneous push and pop (count < DEPTH): count unchanged, both take effect.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH exactly.
REQ-028 port_en is sampled on the pop edge only; changes do not affect already-forwarded words.
REQ-029 dout_en SHALL be a one-cycle pulse per forwarded word; back-to-back forwards give continuous dout_en.

Reset
REQ-030 While reset=1 on an edge: pointers, count, drop_cnt, dout, dout_addr, dout_en SHALL load 0; push/pop suppressed.
REQ-031 Reset mid-operation SHALL flush all queued words without forwarding or counting them as drops.
REQ-032 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-033 Package router_pkg SHALL hold NUM_PORTS=4, ADDR_W=2, DROP_CNT_W=8 and the entry struct {addr, data}.
REQ-034 Storage SHALL be a sub-module sync_fifo (DEPTH x (ADDR_W+DATA_WIDTH), registered pointers, count, full/empty); drop/forward logic and output register live in router_ingress_queue.

Verification
REQ-035 Basic: port_en=4'hF, out_ready=1, push 0xA5A5A5A5 addr 2 on edge 0 -> dout_en=1, dout=0xA5A5A5A5, dout_addr=2 after edge 1 only.
REQ-036 Full: out_ready=0, push 9 words with in_valid held -> in_ready=0 after 8th push, count=8, 9th not accepted; raise out_ready -> 8 words forwarded in order on 8 consecutive cycles.
REQ-037 Drop: port_en=4'b1101, queue words to addr 0,1,3 -> addr 1 word discarded (no dout_en), drop_cnt=1, addrs 0 and 3 forwarded in order.
REQ-038 Saturation: 300 pushes all to disabled port -> drop_cnt=255, count returns to 0.
REQ-039 Reset mid-run: 5 words queued, reset pulsed 1 cycle -> count=0, dout_en=0, drop_cnt=0, no stale word emitted afterwards.
REQ-040 Concurrent: count=4, push and forward on same edge for 10 cycles -> count stays 4, output sequence matches input order.
